// File: rtl/cache_line_arbiter.sv
// Round-robin arbiter sharing one burst memory port between the I-cache (read)
// and D-cache (read/writeback); moves 256-bit lines as 4 x 64-bit beats.
module cache_line_arbiter #(
    parameter int unsigned LINE_W = 256,
    parameter int unsigned BEAT_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [31:0]       i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [31:0]       d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_addr,
    output logic [BEAT_W-1:0] mem_wdata,
    input  logic [BEAT_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    localparam int unsigned BEATS   = LINE_W / BEAT_W;
    localparam int unsigned CNT_W   = $clog2(BEATS);
    localparam int unsigned LSB_W   = $clog2(LINE_W);
    localparam int unsigned OFS_W   = $clog2(BEAT_W);
    localparam int unsigned ALIGN_W = 5;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        I_RD = 3'd1,
        D_RD = 3'd2,
        D_WR = 3'd3,
        RESP = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               last_d_q, last_d_d;
    logic [LINE_W-1:0]  buf_q, buf_d;
    logic [31:0]        addr_q, addr_d;

    logic               i_pend, d_pend, last_beat;
    logic [LSB_W-1:0]   beat_lsb;

    assign i_pend    = i_read;
    assign d_pend    = d_read | d_write;
    assign last_beat = (cnt_q == CNT_W'(BEATS - 1));
    assign beat_lsb  = {cnt_q, {OFS_W{1'b0}}};

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            last_d_q <= 1'b1;
            buf_q    <= '0;
            addr_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_d_q <= last_d_d;
            buf_q    <= buf_d;
            addr_q   <= addr_d;
        end
    end

    // Next state: arbitration at IDLE, beat sequencing during bursts
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_d_d = last_d_q;
        buf_d    = buf_q;
        addr_d   = addr_q;
        unique case (state_q)
            IDLE: begin
                // I wins when alone, or when D was the last one served
                if (i_pend && (!d_pend || last_d_q)) begin
                    state_d  = I_RD;
                    last_d_d = 1'b0;
                    addr_d   = {i_addr[31:ALIGN_W], {ALIGN_W{1'b0}}};
                end else if (d_pend) begin
                    last_d_d = 1'b1;
                    addr_d   = {d_addr[31:ALIGN_W], {ALIGN_W{1'b0}}};
                    if (d_write) begin
                        state_d = D_WR;
                        buf_d   = d_wdata;
                    end else begin
                        state_d = D_RD;
                    end
                end
            end
            I_RD, D_RD: begin
                if (mem_resp) begin
                    buf_d[beat_lsb +: BEAT_W] = mem_rdata;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last_beat) begin
                        state_d = RESP;
                    end
                end
            end
            D_WR: begin
                if (mem_resp) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last_beat) begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded purely from registered state
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        i_resp    = 1'b0;
        d_resp    = 1'b0;
        i_rdata   = buf_q;
        d_rdata   = buf_q;
        unique case (state_q)
            I_RD, D_RD: begin
                mem_read = 1'b1;
                mem_addr = addr_q;
            end
            D_WR: begin
                mem_write = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = buf_q[beat_lsb +: BEAT_W];
            end
            RESP: begin
                i_resp = ~last_d_q;
                d_resp = last_d_q;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_cache_line_arbiter.sv
// Directed bench for cache_line_arbiter: bursts, arbitration, wait states, reset abort.
module tb_cache_line_arbiter;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         i_read = 1'b0;
    logic [31:0]  i_addr = '0;
    logic [255:0] i_rdata;
    logic         i_resp;
    logic         d_read = 1'b0;
    logic         d_write = 1'b0;
    logic [31:0]  d_addr = '0;
    logic [255:0] d_wdata = '0;
    logic [255:0] d_rdata;
    logic         d_resp;
    logic         mem_read;
    logic         mem_write;
    logic [31:0]  mem_addr;
    logic [63:0]  mem_wdata;
    logic [63:0]  mem_rdata = '0;
    logic         mem_resp = 1'b0;

    int errors = 0;
    int checks = 0;

    cache_line_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .i_read   (i_read),
        .i_addr   (i_addr),
        .i_rdata  (i_rdata),
        .i_resp   (i_resp),
        .d_read   (d_read),
        .d_write  (d_write),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_rdata  (d_rdata),
        .d_resp   (d_resp),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_resp (mem_resp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] mkline(input logic [7:0] b0, input logic [7:0] b1,
                                            input logic [7:0] b2, input logic [7:0] b3);
        return {{8{b3}}, {8{b2}}, {8{b1}}, {8{b0}}};
    endfunction

    // Act as memory for one burst; returns on the negedge of the response cycle
    task automatic run_burst(input bit wr, input logic [31:0] exp_addr, input int waits,
                             input logic [255:0] line, output int resp_cyc);
        int beats = 0;
        int w = 0;
        int cyc = 0;
        while (beats < 4 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            check("mem_read", 256'(mem_read), 256'(!wr));
            check("mem_write", 256'(mem_write), 256'(wr));
            check("mem_addr", 256'(mem_addr), 256'(exp_addr));
            if (wr) check("mem_wdata", 256'(mem_wdata), 256'(line[64*beats +: 64]));
            if (w == waits) begin
                mem_resp  = 1'b1;
                mem_rdata = wr ? 64'h0 : line[64*beats +: 64];
                beats++;
                w = 0;
            end else begin
                mem_resp  = 1'b0;
                mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
                w++;
            end
        end
        check("burst_beats", 256'(beats), 256'(4));
        @(negedge clk);
        cyc++;
        mem_resp  = 1'b0;
        mem_rdata = '0;
        resp_cyc  = cyc;
    endtask

    task automatic check_resp(input bit is_i, input logic [255:0] line);
        check("i_resp", 256'(i_resp), 256'(is_i));
        check("d_resp", 256'(d_resp), 256'(!is_i));
        check("i_rdata", i_rdata, line);
        check("d_rdata", d_rdata, line);
        check("resp_bus_idle", 256'({mem_read, mem_write}), 256'(2'b00));
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        check("idle_bus", 256'({mem_read, mem_write, i_resp, d_resp}), 256'(4'b0000));
    endtask

    logic [255:0] l1, lw, la, lb, lc, ld, lx, l6, l7;
    int c;

    initial begin
        l1 = mkline(8'h11, 8'h22, 8'h33, 8'h44);
        lw = mkline(8'hA0, 8'hA1, 8'hA2, 8'hA3);
        la = mkline(8'h01, 8'h02, 8'h03, 8'h04);
        lb = mkline(8'h05, 8'h06, 8'h07, 8'h08);
        lc = mkline(8'h09, 8'h0A, 8'h0B, 8'h0C);
        ld = mkline(8'h0D, 8'h0E, 8'h0F, 8'h10);
        lx = mkline(8'hC1, 8'hC2, 8'hC3, 8'hC4);
        l6 = mkline(8'h55, 8'h66, 8'h77, 8'h88);
        l7 = mkline(8'hB0, 8'hB1, 8'hB2, 8'hB3);

        // Reset state
        @(negedge clk);
        check("rst_outs", 256'({mem_read, mem_write, i_resp, d_resp}), 256'(4'b0000));
        check("rst_addr", 256'(mem_addr), 256'(0));
        check("rst_rdata", i_rdata | d_rdata, 256'(0));
        rst = 1'b1;

        // I-only read, zero wait
        @(negedge clk);
        i_read = 1'b1; i_addr = 32'h0000_1234;
        run_burst(1'b0, 32'h0000_1220, 0, l1, c);
        check("i_lat", 256'(c), 256'(5));
        check_resp(1'b1, l1);
        i_read = 1'b0;

        // D writeback
        idle_cycle();
        d_write = 1'b1; d_addr = 32'h8000_0040; d_wdata = lw;
        run_burst(1'b1, 32'h8000_0040, 0, lw, c);
        check("wr_lat", 256'(c), 256'(5));
        check_resp(1'b0, lw);
        d_write = 1'b0;

        // Fresh reset so last_grant=D, then both held: I, D, I, D
        idle_cycle();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        i_read = 1'b1; i_addr = 32'h0000_0100;
        d_read = 1'b1; d_addr = 32'h0000_0200;
        run_burst(1'b0, 32'h0000_0100, 0, la, c);
        check_resp(1'b1, la);
        idle_cycle();
        run_burst(1'b0, 32'h0000_0200, 0, lb, c);
        check_resp(1'b0, lb);
        idle_cycle();
        run_burst(1'b0, 32'h0000_0100, 0, lc, c);
        check_resp(1'b1, lc);
        idle_cycle();
        run_burst(1'b0, 32'h0000_0200, 0, ld, c);
        check_resp(1'b0, ld);
        i_read = 1'b0; d_read = 1'b0;

        // Three wait cycles per beat
        idle_cycle();
        i_read = 1'b1; i_addr = 32'h0000_0ABC;
        run_burst(1'b0, 32'h0000_0AA0, 3, lx, c);
        check("wait_lat", 256'(c), 256'(17));
        check_resp(1'b1, lx);
        i_read = 1'b0;

        // Reset during a D read after two beats
        idle_cycle();
        d_read = 1'b1; d_addr = 32'h3000_0010;
        @(negedge clk);
        check("abort_rd", 256'(mem_read), 256'(1));
        mem_resp = 1'b1; mem_rdata = 64'hEEEE_EEEE_EEEE_EEEE;
        @(negedge clk);
        mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        mem_resp = 1'b0;
        rst = 1'b0;
        #1;
        check("abort_outs", 256'({mem_read, mem_write, i_resp, d_resp}), 256'(4'b0000));
        check("abort_addr", 256'({mem_addr, mem_wdata}), 256'(0));
        check("abort_data", i_rdata | d_rdata, 256'(0));
        @(negedge clk);
        check("abort_noresp", 256'(d_resp), 256'(0));
        rst = 1'b1;
        run_burst(1'b0, 32'h3000_0000, 0, l6, c);
        check("reissue_lat", 256'(c), 256'(5));
        check_resp(1'b0, l6);
        d_read = 1'b0;

        // Read and write together -> write; then stray mem_resp in IDLE
        idle_cycle();
        d_read = 1'b1; d_write = 1'b1; d_addr = 32'h4000_007F; d_wdata = l7;
        run_burst(1'b1, 32'h4000_0060, 0, l7, c);
        check_resp(1'b0, l7);
        d_read = 1'b0; d_write = 1'b0;
        mem_resp = 1'b1;
        for (int k = 0; k < 3; k++) begin
            idle_cycle();
            check("stray_data", d_rdata, l7);
        end
        mem_resp = 1'b0;
        i_read = 1'b1; i_addr = 32'h0000_2000;
        run_burst(1'b0, 32'h0000_2000, 0, l1, c);
        check("post_stray_lat", 256'(c), 256'(5));
        check_resp(1'b1, l1);
        i_read = 1'b0;
        idle_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
